// File: rtl/dp_link_train_pkg.sv
// Shared types and constants for the DisplayPort link-training sequencer:
// state encoding, phy mode codes, DPCD register map and sink status checks.
package dp_link_train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WRBW,
    ST_WRLC,
    ST_WRTP1,
    ST_WAIT1,
    ST_RDST1,
    ST_WRTP2,
    ST_WAIT2,
    ST_RDST2,
    ST_RDAL,
    ST_WROFF,
    ST_DONE,
    ST_FAIL
  } lt_state_t;

  localparam logic [2:0] PHY_IDLE   = 3'd0;
  localparam logic [2:0] PHY_NORMAL = 3'd1;
  localparam logic [2:0] PHY_TPS1   = 3'd2;
  localparam logic [2:0] PHY_TPS2   = 3'd3;

  localparam logic [19:0] DPCD_LINKBW   = 20'h00100;
  localparam logic [19:0] DPCD_LANECNT  = 20'h00101;
  localparam logic [19:0] DPCD_TRAINPAT = 20'h00102;
  localparam logic [19:0] DPCD_LANE01ST = 20'h00202;
  localparam logic [19:0] DPCD_ALIGN    = 20'h00204;

  localparam logic [7:0] LC_ENH_FRAMING = 8'h80;
  localparam logic [7:0] TP_PAT1        = 8'h21;
  localparam logic [7:0] TP_PAT2        = 8'h22;
  localparam logic [7:0] TP_OFF         = 8'h00;
  localparam logic [7:0] ALIGN_MASK     = 8'h01;

  // Lane 0 status lives in bits [2:0], lane 1 in bits [6:4] of DPCD 0x202.
  function automatic logic [7:0] cr_mask(input logic two);
    return two ? 8'h11 : 8'h01;
  endfunction

  function automatic logic [7:0] eq_mask(input logic two);
    return two ? 8'h77 : 8'h07;
  endfunction

  function automatic logic status_ok(input logic [7:0] st, input logic [7:0] mask);
    return (st & mask) == mask;
  endfunction

  function automatic logic [19:0] req_addr(input lt_state_t s);
    case (s)
      ST_WRBW:                     return DPCD_LINKBW;
      ST_WRLC:                     return DPCD_LANECNT;
      ST_WRTP1, ST_WRTP2, ST_WROFF: return DPCD_TRAINPAT;
      ST_RDST1, ST_RDST2:          return DPCD_LANE01ST;
      ST_RDAL:                     return DPCD_ALIGN;
      default:                     return 20'h00000;
    endcase
  endfunction

  function automatic logic req_write(input lt_state_t s);
    return s inside {ST_WRBW, ST_WRLC, ST_WRTP1, ST_WRTP2, ST_WROFF};
  endfunction

endpackage

// File: rtl/dp_link_train_if.sv
// Request/ack port between the link-training sequencer and the AUX channel engine.
interface dp_link_train_if;
  logic        auxreq;
  logic        auxwr;
  logic [19:0] auxaddr;
  logic [7:0]  auxwdata;
  logic        auxack;
  logic        auxerr;
  logic [7:0]  auxrdata;

  modport master (
    output auxreq, auxwr, auxaddr, auxwdata,
    input  auxack, auxerr, auxrdata
  );

  modport slave (
    input  auxreq, auxwr, auxaddr, auxwdata,
    output auxack, auxerr, auxrdata
  );
endinterface

// File: rtl/dp_link_train.sv
// DisplayPort link-training sequencer: programs the sink over AUX, steps the phy
// through TPS1/TPS2 to normal video and reports trained/failed.
module dp_link_train
  import dp_link_train_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 13500,
  parameter int unsigned MAXTRY   = 5,
  parameter logic [7:0]  LINKBW   = 8'h0A
) (
  input  logic       dpclk,
  input  logic       reset,
  input  logic       start,
  input  logic       twolane,
  output logic [2:0] phymode,
  output logic       trained,
  output logic       failed,
  dp_link_train_if.master aux
);

  // The try counter is 3 bits wide, so MAXTRY must not exceed 7.
  localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYC - 1);
  localparam logic [2:0]  TRY_LIMIT = 3'(MAXTRY);

  lt_state_t   state, state_d, retry_st;
  logic [15:0] wait_cnt, wait_d;
  logic [2:0]  try_cnt, try_d, try_inc;
  logic        lanesel, lanesel_d;
  logic        req_d, wr_d;
  logic [19:0] addr_d;
  logic [7:0]  wdata_d;
  logic [2:0]  phy_d;
  logic        trained_d, failed_d;
  logic        issue, retry;

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    try_d     = try_cnt;
    lanesel_d = lanesel;
    req_d     = aux.auxreq;
    wr_d      = aux.auxwr;
    addr_d    = aux.auxaddr;
    wdata_d   = aux.auxwdata;
    phy_d     = phymode;
    trained_d = trained;
    failed_d  = failed;
    issue     = 1'b0;
    retry     = 1'b0;
    retry_st  = ST_WAIT1;
    try_inc   = try_cnt + 3'd1;

    unique case (state)
      ST_IDLE, ST_DONE, ST_FAIL: ;
      ST_WAIT1, ST_WAIT2: begin
        // Issue the status read on the same edge the wait expires.
        if (wait_cnt == 16'd0) begin
          state_d = (state == ST_WAIT1) ? ST_RDST1 : ST_RDST2;
          issue   = 1'b1;
        end else begin
          wait_d = wait_cnt - 16'd1;
        end
      end
      default: begin
        // AUX states: one idle cycle after entry, then request until acked.
        if (!aux.auxreq) begin
          issue = 1'b1;
        end else if (aux.auxack) begin
          req_d = 1'b0;
          if (aux.auxerr) begin
            state_d = ST_FAIL;
          end else begin
            unique case (state)
              ST_WRBW:  state_d = ST_WRLC;
              ST_WRLC:  state_d = ST_WRTP1;
              ST_WRTP1: begin
                state_d = ST_WAIT1;
                wait_d  = WAIT_LOAD;
              end
              ST_RDST1: begin
                if (status_ok(aux.auxrdata, cr_mask(lanesel))) begin
                  try_d   = 3'd0;
                  state_d = ST_WRTP2;
                end else begin
                  retry    = 1'b1;
                  retry_st = ST_WAIT1;
                end
              end
              ST_WRTP2: begin
                state_d = ST_WAIT2;
                wait_d  = WAIT_LOAD;
              end
              ST_RDST2: begin
                if (status_ok(aux.auxrdata, eq_mask(lanesel))) begin
                  state_d = ST_RDAL;
                end else begin
                  retry    = 1'b1;
                  retry_st = ST_WAIT2;
                end
              end
              ST_RDAL: begin
                if (status_ok(aux.auxrdata, ALIGN_MASK)) begin
                  state_d = ST_WROFF;
                end else begin
                  retry    = 1'b1;
                  retry_st = ST_WAIT2;
                end
              end
              ST_WROFF: begin
                state_d   = ST_DONE;
                trained_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    if (retry) begin
      try_d = try_inc;
      if (try_inc == TRY_LIMIT) begin
        state_d = ST_FAIL;
      end else begin
        state_d = retry_st;
        wait_d  = WAIT_LOAD;
      end
    end

    if (issue) begin
      req_d  = 1'b1;
      wr_d   = req_write(state_d);
      addr_d = req_addr(state_d);
      unique case (state_d)
        ST_WRBW:  wdata_d = LINKBW;
        ST_WRLC:  wdata_d = LC_ENH_FRAMING | (lanesel ? 8'h02 : 8'h01);
        ST_WRTP1: begin
          wdata_d = TP_PAT1;
          phy_d   = PHY_TPS1;
        end
        ST_WRTP2: begin
          wdata_d = TP_PAT2;
          phy_d   = PHY_TPS2;
        end
        ST_WROFF: begin
          wdata_d = TP_OFF;
          phy_d   = PHY_NORMAL;
        end
        default:  wdata_d = 8'h00;
      endcase
    end

    if (state_d == ST_FAIL && state != ST_FAIL) begin
      req_d    = 1'b0;
      phy_d    = PHY_IDLE;
      failed_d = 1'b1;
    end

    // start wins over anything else this cycle, including a coincident auxack.
    if (start) begin
      state_d   = ST_WRBW;
      req_d     = 1'b0;
      lanesel_d = twolane;
      trained_d = 1'b0;
      failed_d  = 1'b0;
      try_d     = 3'd0;
      wait_d    = 16'd0;
      phy_d     = PHY_IDLE;
    end
  end

  always_ff @(posedge dpclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= 16'd0;
      try_cnt      <= 3'd0;
      lanesel      <= 1'b0;
      aux.auxreq   <= 1'b0;
      aux.auxwr    <= 1'b0;
      aux.auxaddr  <= 20'h00000;
      aux.auxwdata <= 8'h00;
      phymode      <= PHY_IDLE;
      trained      <= 1'b0;
      failed       <= 1'b0;
    end else begin
      state        <= state_d;
      wait_cnt     <= wait_d;
      try_cnt      <= try_d;
      lanesel      <= lanesel_d;
      aux.auxreq   <= req_d;
      aux.auxwr    <= wr_d;
      aux.auxaddr  <= addr_d;
      aux.auxwdata <= wdata_d;
      phymode      <= phy_d;
      trained      <= trained_d;
      failed       <= failed_d;
    end
  end

endmodule

// File: doc/dp_link_train.md
Name: dp_link_train

Overview:
- Link-training sequencer for the DisplayPort transmit path.
- Drives the phy mode select (training pattern 1, training pattern 2, normal video) and issues DPCD reads/writes through a request/ack port to the AUX channel engine.
- Raises `trained` once the sink reports clock recovery, equalisation, symbol lock and inter-lane alignment. Top level gates the stream path (pxclk/stuff DMA start) with `trained`.
- Supports 1 or 2 lanes, selected by the twolane attribute bit.

Parameters:
- WAIT_CYC, 13500, dpclk cycles between the training-pattern write and the status read (100 us at 135 MHz).
- MAXTRY, 5, status polls allowed per training phase before failure.
- LINKBW, 8'h0A, value written to DPCD 0x100 (2.7 Gb/s).

Ports:
- dpclk  in  1  link clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts training from any state.
- twolane  in  1  1 = two lanes, 0 = lane 0 only; sampled on start.
- phymode  out  3  phy mode: 0 idle, 1 normal, 2 TPS1, 3 TPS2.
- auxreq  out  1  AUX transaction request; held high until auxack.
- auxwr  out  1  1 = write, 0 = read; valid while auxreq.
- auxaddr  out  20  DPCD address; valid while auxreq.
- auxwdata  out  8  write byte; valid while auxreq.
- auxack  in  1  one-cycle completion pulse from the AUX engine.
- auxerr  in  1  qualifies auxack; transaction failed (NACK/timeout).
- auxrdata  in  8  read byte; valid with auxack.
- trained  out  1  link trained; stream may run.
- failed  out  1  training aborted; sticky until next start or reset.

Behaviour:
- Reset: phymode=0, auxreq=0, auxwr=0, auxaddr=0, auxwdata=0, trained=0, failed=0. State=IDLE, try counter=0, wait counter=0.
- Start handling:
  - start latches twolane into lanesel.
  - start clears trained and failed, enters WRBW, and asserts auxreq on the next cycle.
  - start mid-sequence abandons any outstanding request: auxreq drops for one cycle, then WRBW restarts. A late auxack arriving during that gap is ignored.
- AUX handshake:
  - auxreq, auxwr, auxaddr and auxwdata are registered and stable from assertion until the auxack cycle.
  - auxreq is low in the cycle after auxack.
  - Only one request is outstanding at a time.
  - auxack with auxerr=1 in any state goes to FAIL.
- States (each AUX state advances on auxack with auxerr=0):
  - IDLE: wait for start.
  - WRBW: write 0x100 = LINKBW.
  - WRLC: write 0x101 = 8'h80 | (lanesel ? 2 : 1). Bit 7 is enhanced framing.
  - WRTP1: phymode=2 on entry, in the same cycle auxreq rises. Write 0x102 = 8'h21. Load wait counter = WAIT_CYC-1.
  - WAIT1: count down to 0, then go to RDST1.
  - RDST1: read 0x202. Pass when bit0 is set, and also bit4 when lanesel=1. Pass: clear try counter, go to WRTP2. Fail: increment try; if try==MAXTRY go to FAIL, else go to WAIT1.
  - WRTP2: phymode=3 on entry. Write 0x102 = 8'h22. Load wait counter = WAIT_CYC-1.
  - WAIT2: count down to 0, then go to RDST2.
  - RDST2: read 0x202. Require bits[2:0]=3'b111, and also bits[6:4] when lanesel=1.
  - RDAL: read 0x204; bit0 (inter-lane align) is required.
  - RDST2/RDAL failure: increment try and go to WAIT2, or go to FAIL when try reaches MAXTRY.
  - RDAL pass: go to WROFF.
  - WROFF: phymode=1 on entry. Write 0x102 = 8'h00. On ack go to DONE.
  - DONE: trained=1 from the cycle after the WROFF ack. Hold until start or reset.
  - FAIL: phymode=0, failed=1, auxreq=0. Hold until start or reset.
- Width rules:
  - Try counter is 3 bits; MAXTRY must be 7 or less.
  - Wait counter is 16 bits and does not wrap; it stops at 0.
- Simultaneous events: start in the same cycle as auxack gives start priority. Reset overrides everything.

Decomposition:
- dport.vh gains:
  - `PHY_IDLE`, `PHY_NORMAL`, `PHY_TPS1`, `PHY_TPS2`.
  - DPCD address defines: `DPCD_LINKBW` 0x100, `DPCD_LANECNT` 0x101, `DPCD_TRAINPAT` 0x102, `DPCD_LANE01ST` 0x202, `DPCD_ALIGN` 0x204.
- Single module; no sub-module. The wait counter and try counter are inline registers.

Test Plan:
- Reset, then start with twolane=0; AUX model acks every request in 3 cycles with rdata 8'h07 (0x202) and 8'h01 (0x204).
  - Write sequence is 0x100=0A, 0x101=81, 0x102=21, 0x102=22, 0x102=00, with reads of 0x202 and 0x204 in between.
  - phymode goes 0→2→3→1; trained=1 one cycle after the final ack.
- twolane=1 with 0x202 returning 8'h07 → CR check fails; after 5 polls failed=1 and phymode=0. With 8'h77, training passes.
- 0x202 returns 8'h00 on the first two RDST1 polls, then 8'h01 → exactly 3 reads of 0x202 in phase 1, each preceded by WAIT_CYC idle cycles (measured with WAIT_CYC=16); training then proceeds.
- auxerr=1 on the WRLC ack → failed=1 next cycle, auxreq low, and no further requests.
- start pulsed during WAIT2 → auxreq low for one cycle, then the WRBW request reappears with 0x100; a stale auxack injected in the gap is ignored.
- auxack withheld for 200 cycles → auxreq, auxaddr and auxwdata remain constant throughout; reset asserted mid-request returns all outputs to their reset values.
